// File: rtl/mpadd_seq.sv
// Word-serial multi-precision adder/subtractor: operands stream in LS word first,
// one 33-bit add per accepted word pair, result words stream out with a valid/ready handshake.
module mpadd_seq #(
  parameter int NWORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sub,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_word,
  input  logic [31:0] b_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum_word,
  output logic        out_last,
  output logic        cout_final,
  output logic        ovf,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(NWORDS) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic [32:0] add_word(input logic [31:0] a, input logic [31:0] b,
                                           input logic cin);
    return {1'b0, a} + {1'b0, b} + {32'd0, cin};
  endfunction

  state_t         state_r, state_n;
  logic           sub_r, sub_n;
  logic           carry_r, carry_n;
  logic [CW-1:0]  cnt_r, cnt_n;
  logic [31:0]    sum_r, sum_n;
  logic           valid_r, valid_n;
  logic           last_r, last_n;
  logic           cout_r, cout_n;
  logic           ovf_r, ovf_n;
  logic           busy_r;
  logic           done_r, done_n;

  logic [31:0]    b_eff_s;
  logic [32:0]    add_s;
  logic           in_ready_s;
  logic           xfer_s;
  logic           pop_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state, handshake and datapath next values.
  always_comb begin
    state_n = state_r;
    sub_n   = sub_r;
    carry_n = carry_r;
    cnt_n   = cnt_r;
    sum_n   = sum_r;
    valid_n = valid_r;
    last_n  = last_r;
    cout_n  = cout_r;
    ovf_n   = ovf_r;
    done_n  = 1'b0;

    b_eff_s    = sub_r ? ~b_word : b_word;
    add_s      = add_word(a_word, b_eff_s, carry_r);
    in_ready_s = (state_r == RUN) && (!valid_r || out_ready);
    xfer_s     = in_valid && in_ready_s;
    pop_s      = valid_r && out_ready;

    case (state_r)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          sub_n   = sub;
          carry_n = sub;
          cnt_n   = {CW{1'b0}};
          cout_n  = 1'b0;
          ovf_n   = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (xfer_s) begin
          // A new word replaces any word being popped in the same cycle.
          sum_n   = add_s[31:0];
          valid_n = 1'b1;
          carry_n = add_s[32];
          cnt_n   = cnt_r + CW'(1);
          last_n  = (cnt_r == LAST_IDX);
          if (cnt_r == LAST_IDX) begin
            cout_n  = add_s[32];
            ovf_n   = (a_word[31] == b_eff_s[31]) && (add_s[31] != a_word[31]);
            state_n = DRAIN;
          end else begin
            state_n = RUN;
          end
        end else if (pop_s) begin
          valid_n = 1'b0;
        end else begin
          valid_n = valid_r;
        end
      end
      DRAIN: begin
        if (pop_s && last_r) begin
          valid_n = 1'b0;
          last_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = DRAIN;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_r   <= 1'b0;
      carry_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      sum_r   <= 32'd0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      sub_r   <= sub_n;
      carry_r <= carry_n;
      cnt_r   <= cnt_n;
      sum_r   <= sum_n;
      valid_r <= valid_n;
      last_r  <= last_n;
      cout_r  <= cout_n;
      ovf_r   <= ovf_n;
      busy_r  <= (state_n != IDLE);
      done_r  <= done_n;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = valid_r;
  assign sum_word   = sum_r;
  assign out_last   = last_r;
  assign cout_final = cout_r;
  assign ovf        = ovf_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_mpadd_seq.sv
// Directed bench for mpadd_seq (NWORDS=4): carry/borrow chains, overflow,
// backpressure, ignored start/in_valid, and mid-operation reset.
module tb_mpadd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_word;
  logic [31:0] b_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum_word;
  logic        out_last;
  logic        cout_final;
  logic        ovf;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] av [4];
  logic [31:0] bv [4];
  logic [31:0] ev [4];

  mpadd_seq #(.NWORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
    .in_valid(in_valid), .in_ready(in_ready), .a_word(a_word), .b_word(b_word),
    .out_valid(out_valid), .out_ready(out_ready), .sum_word(sum_word),
    .out_last(out_last), .cout_final(cout_final), .ovf(ovf), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full operation with optional output stall and optional start pulse in RUN.
  task automatic run_op(input string name, input logic s, input int stall_after,
                        input int stall_cycles, input bit glitch,
                        input logic exp_cout, input logic exp_ovf);
    logic [31:0] gotw [4];
    logic        gotl [4];
    int idx, ngot, cyc, done_cyc, last_cyc, stall_left;
    for (int i = 0; i < 4; i++) begin
      gotw[i] = 32'd0;
      gotl[i] = 1'b0;
    end
    idx = 0; ngot = 0; cyc = 0; done_cyc = -1; last_cyc = -1; stall_left = stall_cycles;
    in_valid = 1'b0; out_ready = 1'b1; start = 1'b1; sub = s;
    @(negedge clk);
    start = 1'b0; sub = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b1 || cout_final !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start: busy/cout/ovf got %b%b%b, expected 100", name, busy, cout_final, ovf);
    end
    while (done_cyc < 0 && cyc < 40) begin
      in_valid  = 1'b1;
      a_word    = (idx < 4) ? av[idx] : 32'hDEAD_BEEF;
      b_word    = (idx < 4) ? bv[idx] : 32'h1234_5678;
      start     = glitch && (idx == 1);
      sub       = start ? ~s : 1'b0;
      out_ready = !(ngot == stall_after && stall_left > 0);
      #1;
      if (done) done_cyc = cyc;
      if (out_valid && !out_ready) begin
        stall_left--;
        n_checks++;
        if (in_ready !== 1'b0 || ngot > 3 || sum_word !== ev[ngot & 3]) begin
          n_fail++;
          $display("FAIL %s stall: in_ready=%b sum=%h, expected in_ready=0 sum=%h",
                   name, in_ready, sum_word, ev[ngot & 3]);
        end
      end
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        if (ngot < 4) begin
          gotw[ngot] = sum_word;
          gotl[ngot] = out_last;
        end
        ngot++;
        last_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; sub = 1'b0;
    n_checks++;
    if (done_cyc < 0) begin
      n_fail++;
      $display("FAIL %s timeout: done not seen within 40 cycles, expected a done pulse", name);
    end
    n_checks++;
    if (ngot !== 4) begin
      n_fail++;
      $display("FAIL %s count: got %0d words, expected 4", name, ngot);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (gotw[i] !== ev[i] || gotl[i] !== (i == 3)) begin
        n_fail++;
        $display("FAIL %s word%0d: got %h last=%b, expected %h last=%b",
                 name, i, gotw[i], gotl[i], ev[i], (i == 3));
      end
    end
    n_checks++;
    if (done_cyc !== last_cyc + 1) begin
      n_fail++;
      $display("FAIL %s done_timing: got cycle %0d, expected %0d", name, done_cyc, last_cyc + 1);
    end
    n_checks++;
    if (cout_final !== exp_cout || ovf !== exp_ovf || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s flags: cout/ovf/busy got %b%b%b, expected %b%b0",
               name, cout_final, ovf, busy, exp_cout, exp_ovf);
    end
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 ||
          cout_final !== exp_cout || ovf !== exp_ovf) begin
        n_fail++;
        $display("FAIL %s idle_after: valid/done/ready/cout/ovf got %b%b%b%b%b, expected 000%b%b",
                 name, out_valid, done, in_ready, cout_final, ovf, exp_cout, exp_ovf);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_word = 32'd0; b_word = 32'd0;
    #2;
    n_checks++;
    if ({in_ready, out_valid, out_last, cout_final, ovf, busy, done} !== 7'd0 || sum_word !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: flags %b sum %h, expected 0000000 00000000",
               {in_ready, out_valid, out_last, cout_final, ovf, busy, done}, sum_word);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle_ignore();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      a_word = 32'hFFFF_0000 + 32'(i); b_word = 32'h0000_00FF;
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || sum_word !== 32'd0) begin
        n_fail++;
        $display("FAIL idle_ignore: ready/valid/busy %b%b%b sum %h, expected 000 00000000",
                 in_ready, out_valid, busy, sum_word);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_add_carry();
    av = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    bv = '{32'h0000_0001, 32'h0, 32'h0, 32'h0};
    ev = '{32'h0, 32'h0, 32'h0, 32'h0};
    run_op("add_carry", 1'b0, -1, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_sub_small();
    av = '{32'h5, 32'h0, 32'h0, 32'h0};
    bv = '{32'h3, 32'h0, 32'h0, 32'h0};
    ev = '{32'h2, 32'h0, 32'h0, 32'h0};
    run_op("sub_small", 1'b1, -1, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_sub_borrow();
    av = '{32'h0, 32'h0, 32'h0, 32'h0};
    bv = '{32'h1, 32'h0, 32'h0, 32'h0};
    ev = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    run_op("sub_borrow", 1'b1, -1, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_add_ovf();
    av = '{32'h0, 32'h0, 32'h0, 32'h7FFF_FFFF};
    bv = '{32'h0, 32'h0, 32'h0, 32'h0000_0001};
    ev = '{32'h0, 32'h0, 32'h0, 32'h8000_0000};
    run_op("add_ovf", 1'b0, -1, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    av = '{32'h1, 32'h2, 32'h3, 32'h4};
    bv = '{32'h10, 32'h20, 32'h30, 32'h40};
    ev = '{32'h11, 32'h22, 32'h33, 32'h44};
    run_op("backpressure", 1'b0, 1, 3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_start_in_run();
    av = '{32'h8000_0000, 32'h0000_0001, 32'h0, 32'h1};
    bv = '{32'h8000_0000, 32'h0000_0002, 32'h0, 32'h2};
    ev = '{32'h0, 32'h0000_0004, 32'h0, 32'h3};
    run_op("start_in_run", 1'b0, -1, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    av = '{32'h1, 32'h2, 32'h3, 32'h4};
    bv = '{32'h10, 32'h20, 32'h30, 32'h40};
    ev = '{32'h11, 32'h22, 32'h33, 32'h44};
    out_ready = 1'b1; start = 1'b1; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a_word = av[i]; b_word = bv[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || sum_word !== 32'h22 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid pre: valid/busy %b%b sum %h, expected 11 00000022", out_valid, busy, sum_word);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, out_last, cout_final, ovf, busy, done} !== 7'd0 || sum_word !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid clear: flags %b sum %h, expected 0000000 00000000",
               {in_ready, out_valid, out_last, cout_final, ovf, busy, done}, sum_word);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a_word = av[2]; b_word = bv[2];
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid abandon: valid/busy/ready %b%b%b, expected 000", out_valid, busy, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    run_op("reset_mid_rerun", 1'b0, -1, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_add_carry();
    test_sub_small();
    test_sub_borrow();
    test_add_ovf();
    test_backpressure();
    test_start_in_run();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mpadd_seq.md
MPADD_SEQ -- requirements
Module: mpadd_seq

Interface
REQ-001 Parameter: NWORDS, default 4, number of 32-bit words per operand; legal range 2..256.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse that begins a multi-word operation; sampled only in IDLE.
REQ-005 sub  input  1  operation mode, sampled with start: 0 = A+B, 1 = A-B.
REQ-006 in_valid  input  1  an operand word pair is present on a_word/b_word.
REQ-007 in_ready  output  1  the block accepts the operand word pair this cycle.
REQ-008 a_word, b_word  input  32 each  operand words, least-significant word first.
REQ-009 out_valid  output  1  sum_word holds a result word.
REQ-010 out_ready  input  1  the downstream stage accepts sum_word this cycle.
REQ-011 sum_word  output  32  result word, least-significant first.
REQ-012 out_last  output  1  qualifies sum_word as the final (most-significant) word.
REQ-013 cout_final  output  1  carry out of the most-significant word; for sub, 1 = no borrow.
REQ-014 ovf  output  1  two's-complement signed overflow of the full NWORDS*32-bit result.
REQ-015 busy  output  1  high in RUN and DRAIN.
REQ-016 done  output  1  one-cycle pulse when the final word is accepted downstream.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN; encoding is free.
REQ-018 IDLE: in_ready=0; start=1 -> latch sub, carry register <= sub, word counter <= 0, next state RUN.
REQ-019 start SHALL be ignored in RUN and DRAIN; in_valid SHALL be ignored in IDLE and DRAIN.
REQ-020 RUN: in_ready = (!out_valid || out_ready).
REQ-021 Word transfer occurs on in_valid && in_ready; the block SHALL compute {c,s} = a_word + (sub ? ~b_word : b_word) + carry with full 33-bit carry propagation.
REQ-022 On transfer: sum_word <= s, out_valid <= 1, carry <= c, counter += 1, out_last <= (counter == NWORDS-1); latency is 1 cycle from accepted input to out_valid.
REQ-023 On the transfer of word NWORDS-1: cout_final <= c; ovf <= (a31 == b'31) && (s31 != a31), where b' is the possibly inverted b_word; next state DRAIN.
REQ-024 out_valid SHALL clear on out_valid && out_ready unless a new transfer occurs in the same cycle; this gives full throughput of one word per cycle when out_ready is held at 1.
REQ-025 While out_valid=1 && out_ready=0, sum_word and out_last SHALL hold stable and in_ready SHALL be 0.
REQ-026 DRAIN: on out_valid && out_ready with out_last=1 -> out_valid <= 0, out_last <= 0, done pulses for 1 cycle, next state IDLE.
REQ-027 cout_final and ovf SHALL hold from the final transfer until the next accepted start, which clears both to 0.
REQ-028 The word counter SHALL be at least clog2(NWORDS)+1 bits wide and SHALL never wrap within an operation.

Reset
REQ-029 rst_n=0 SHALL immediately force: state IDLE; in_ready, out_valid, out_last, cout_final, ovf, busy, done = 0; sum_word, carry and counter = 0.
REQ-030 Reset asserted mid-operation SHALL abandon the operation with no further output words; the first post-reset operation SHALL require a new start.

Verification (NWORDS=4)
REQ-031 Add, A={FFFFFFFF x4}, B={00000001,0,0,0}, out_ready=1 -> sum_words 0,0,0,0; out_last on 4th word; cout_final=1; ovf=0; done 1 cycle after the 4th word is accepted.
REQ-032 Sub, A={5,0,0,0}, B={3,0,0,0} -> 2,0,0,0; cout_final=1; ovf=0.
REQ-033 Sub, A=0, B={1,0,0,0} -> FFFFFFFF x4; cout_final=0; ovf=0. Add, A={0,0,0,7FFFFFFF}, B={0,0,0,1} -> top word 80000000; ovf=1.
REQ-034 Backpressure: out_ready=0 for 3 cycles after word 1 -> sum_word stable and in_ready=0 throughout; all 4 words delivered in order with none dropped or duplicated.
REQ-035 start pulsed in RUN and in_valid driven in IDLE -> no state, counter or output change.
REQ-036 rst_n pulsed low after word 2 -> all outputs 0 within the same cycle; a new start then yields a correct full 4-word result.
